// File: rtl/decoder_pkg.sv
// Shared types and limits for the N-to-M one-hot decoder with sweep mode.
package decoder_pkg;

    localparam int unsigned MAX_IN_W = 8;

    typedef enum logic {
        DEC_IDLE,
        DEC_SWEEP
    } dec_state_e;

    typedef enum logic {
        DEC_MODE_DIRECT,
        DEC_MODE_SWEEP
    } dec_mode_e;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational binary-to-one-hot decode with an in-range flag.
// DECODER_RANGE_CHECK_EN enables the code < NUM_OUT comparator; otherwise in_range is tied high.
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W    = 5,
    parameter int unsigned NUM_OUT = 32
) (
    input  logic [IN_W-1:0]    code,
    output logic [NUM_OUT-1:0] mask,
    output logic               in_range
);

    // Out-of-range codes match no bit, so the mask is naturally all-zero for them.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            mask[i] = (code == IN_W'(i));
        end
    end

`ifdef DECODER_RANGE_CHECK_EN
    assign in_range = (32'(code) < NUM_OUT);
`else
    assign in_range = 1'b1;
`endif

endmodule

// File: rtl/decoder_nxm_seq.sv
// Registered N-to-M one-hot decoder with valid/ready handshakes and an autonomous sweep mode.
// Range reporting is controlled by DECODER_RANGE_CHECK_EN (see decoder_onehot).
module decoder_nxm_seq
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W    = 5,
    parameter int unsigned NUM_OUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               sweep_start,
    output logic               sweep_busy,
    output logic               sweep_done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] data_out,
    output logic [IN_W-1:0]    code_out,
    output logic               range_err
);

    localparam logic [IN_W-1:0] LAST_CODE = IN_W'(NUM_OUT - 1);

    dec_state_e          state_q, state_d;
    logic [IN_W-1:0]     cnt_q, cnt_d;
    logic                done_d;
    logic                load;
    logic                use_cnt;
    logic                free;
    logic [IN_W-1:0]     code_sel;
    logic [NUM_OUT-1:0]  mask;
    logic                in_range;

    assign free     = !out_valid || out_ready;
    assign in_ready = free && (state_q == DEC_IDLE) && (dec_mode_e'(mode) == DEC_MODE_DIRECT);
    assign code_sel = use_cnt ? cnt_q : data_in;

    decoder_onehot #(
        .IN_W    (IN_W),
        .NUM_OUT (NUM_OUT)
    ) u_onehot (
        .code     (code_sel),
        .mask     (mask),
        .in_range (in_range)
    );

    // Next-state, counter and load select.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        use_cnt = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            DEC_IDLE: begin
                if (sweep_start && (dec_mode_e'(mode) == DEC_MODE_SWEEP)) begin
                    state_d = DEC_SWEEP;
                    cnt_d   = '0;
                end else if (in_valid && in_ready) begin
                    load = 1'b1;
                end
            end
            DEC_SWEEP: begin
                if (free) begin
                    load    = 1'b1;
                    use_cnt = 1'b1;
                    cnt_d   = cnt_q + IN_W'(1);
                    if (cnt_q == LAST_CODE) begin
                        state_d = DEC_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = DEC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DEC_IDLE;
            cnt_q      <= '0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sweep_busy <= (state_d == DEC_SWEEP);
            sweep_done <= done_d;
        end
    end

    // One-entry output slot; a new load takes priority over a retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            code_out  <= '0;
            range_err <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            data_out  <= mask;
            code_out  <= code_sel;
            range_err <= !in_range;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_nxm_seq.sv
// Randomised self-checking bench for decoder_nxm_seq against a cycle-level behavioural model.
module tb_decoder_nxm_seq;

    localparam int IN_W    = 5;
    localparam int NUM_OUT = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic               sweep_start;
    logic               sweep_busy;
    logic               sweep_done;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    data_in;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OUT-1:0] data_out;
    logic [IN_W-1:0]    code_out;
    logic               range_err;

    always #5 clk = ~clk;

    decoder_nxm_seq #(
        .IN_W    (IN_W),
        .NUM_OUT (NUM_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .code_out    (code_out),
        .range_err   (range_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: result slot plus sweep progress as plain integers.
    bit                 m_valid;
    bit                 m_busy;
    bit                 m_done;
    bit                 m_err;
    logic [NUM_OUT-1:0] m_data;
    int                 m_code;
    int                 m_next;

    function automatic logic [NUM_OUT-1:0] ref_decode(input int c);
        logic [NUM_OUT-1:0] one;
        one = NUM_OUT'(1);
        return (c < NUM_OUT) ? (one << c) : '0;
    endfunction

    function automatic bit ref_err(input int c);
`ifdef DECODER_RANGE_CHECK_EN
        return c >= NUM_OUT;
`else
        return (c < 0);
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_busy  = 0;
        m_done  = 0;
        m_err   = 0;
        m_data  = '0;
        m_code  = 0;
        m_next  = 0;
    endtask

    task automatic model_clock();
        bit free;
        bit ld;
        bit dn;
        int c;
        if (rst) begin
            model_reset();
        end else begin
            free = !m_valid || out_ready;
            ld   = 0;
            dn   = 0;
            c    = 0;
            if (m_busy) begin
                if (free) begin
                    ld = 1;
                    c  = m_next;
                    if (m_next == NUM_OUT - 1) begin
                        m_busy = 0;
                        dn     = 1;
                    end
                    m_next++;
                end
            end else if (sweep_start && mode) begin
                m_busy = 1;
                m_next = 0;
            end else if (in_valid && free && !mode) begin
                ld = 1;
                c  = int'(data_in);
            end
            if (ld) begin
                m_valid = 1;
                m_data  = ref_decode(c);
                m_code  = c;
                m_err   = ref_err(c);
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            m_done = dn;
        end
    endtask

    bit collect;
    int seen[$];
    int done_cnt;

    // One clock: check handshake before the edge, outputs after it.
    task automatic step();
        #1;
        check("in_ready", 64'(in_ready), 64'((!m_valid || out_ready) && !m_busy && !mode));
        if (collect && out_valid && out_ready) seen.push_back(int'(code_out));
        @(posedge clk);
        model_clock();
        #1;
        check("out_valid",  64'(out_valid),  64'(m_valid));
        check("data_out",   64'(data_out),   64'(m_data));
        check("code_out",   64'(code_out),   64'(m_code));
        check("range_err",  64'(range_err),  64'(m_err));
        check("sweep_busy", 64'(sweep_busy), 64'(m_busy));
        check("sweep_done", 64'(sweep_done), 64'(m_done));
        if (collect && sweep_done) done_cnt++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst         = 1;
        mode        = 0;
        sweep_start = 0;
        in_valid    = 0;
        out_ready   = 1;
        data_in     = '0;
        collect     = 0;
        done_cnt    = 0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset held for two cycles, then released in direct mode
        step();
        step();
        rst = 0;
        step();

        // Back-to-back direct codes covering in-range and out-of-range values
        in_valid  = 1;
        out_ready = 1;
        for (int i = 0; i < 32; i++) begin
            data_in = IN_W'(i);
            step();
        end
        in_valid = 0;
        step();

        // Backpressure: 7 held for three cycles, then retire and accept 9 together
        in_valid = 1;
        data_in  = IN_W'(7);
        step();
        data_in   = IN_W'(9);
        out_ready = 0;
        repeat (3) step();
        out_ready = 1;
        step();
        check("bp_code9", 64'(code_out), 64'(9));
        in_valid = 0;
        step();

        // Explicit out-of-range code
        in_valid = 1;
        data_in  = IN_W'(25);
        step();
        check("range_code25", 64'(code_out), 64'(25));
        check("range_data0",  64'(data_out), 64'(0));
        in_valid = 0;
        step();

        // Random direct traffic; sweep_start must be ignored in direct mode
        for (int i = 0; i < 200; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            data_in     = IN_W'($urandom_range(0, 31));
            sweep_start = ($urandom_range(0, 7) == 0);
            step();
        end
        sweep_start = 0;
        in_valid    = 0;
        out_ready   = 1;
        step();

        // Sweep with a two-cycle stall and mode toggling while busy
        seen.delete();
        done_cnt = 0;
        collect  = 1;
        for (int k = 0; k < NUM_OUT + 10; k++) begin
            sweep_start = (k == 0);
            mode        = (k == 0 || k >= NUM_OUT) ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready   = !(k == 5 || k == 6);
            in_valid    = 1'($urandom_range(0, 1));
            data_in     = IN_W'($urandom_range(0, 31));
            step();
        end
        collect     = 0;
        sweep_start = 0;
        in_valid    = 0;
        check("sweep_count", 64'(seen.size()), 64'(NUM_OUT));
        for (int i = 0; i < seen.size(); i++) begin
            check("sweep_order", 64'(seen[i]), 64'(i));
        end
        check("sweep_done_pulses", 64'(done_cnt), 64'(1));

        // Reset in the middle of a sweep, then restart from code 0
        mode        = 1;
        out_ready   = 1;
        sweep_start = 1;
        step();
        sweep_start = 0;
        found       = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (out_valid && code_out == IN_W'(10)) begin
                found = 1;
                break;
            end
        end
        check("mid_sweep_reach", 64'(found), 64'(1));
        rst = 1;
        step();
        check("rst_busy",  64'(sweep_busy), 64'(0));
        check("rst_valid", 64'(out_valid),  64'(0));
        rst         = 0;
        sweep_start = 1;
        step();
        sweep_start = 0;
        step();
        check("restart_valid", 64'(out_valid), 64'(1));
        check("restart_code0", 64'(code_out),  64'(0));
        repeat (NUM_OUT + 3) step();

        // Random mixed traffic including occasional resets
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            mode        = 1'($urandom_range(0, 1));
            sweep_start = ($urandom_range(0, 7) == 0);
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            data_in     = IN_W'($urandom_range(0, 31));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
